// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback controller: opcodes,
// instruction field layout and datapath widths.
package alu_pkg;

  localparam int OP_W      = 3;
  localparam int REG_IDX_W = 2;
  localparam int DATA_W    = 8;
  localparam int BR_W      = 6;
  localparam int INSTR_W   = 16;

  localparam int OP_LSB = 13;
  localparam int RD_LSB = 11;
  localparam int RA_LSB = 9;
  localparam int RB_LSB = 7;
  localparam int RSV_BIT = 6;
  localparam int BR_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_BEQ = 3'b111;

  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction stream from fetch into the issue controller.
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational read ports, one write port,
// asynchronous reset to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra_idx,
  input  logic [REG_IDX_W-1:0] rb_idx,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign ra_data = regs[ra_idx];
  assign rb_data = regs[rb_idx];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU: registers operands (I stage),
// retires the ALU result one cycle later (W stage), owns flags and branches.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_ctrl_if.slave       in_if,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_instr,
  output logic [BR_W-1:0]       alu_branch_addr,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_co,
  output logic                  wb_valid,
  output logic [REG_IDX_W-1:0]  wb_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  carry_flag,
  output logic                  eq_flag,
  output logic                  redirect_valid,
  output logic [BR_W-1:0]       redirect_addr,
  output logic [CNT_W-1:0]      retired_count
);

  logic [OP_W-1:0]      in_op;
  logic [REG_IDX_W-1:0] in_rd, in_ra, in_rb;
  logic [BR_W-1:0]      in_br;
  logic                 unused_rsvd;

  assign in_op       = in_if.in_instr[OP_LSB +: OP_W];
  assign in_rd       = in_if.in_instr[RD_LSB +: REG_IDX_W];
  assign in_ra       = in_if.in_instr[RA_LSB +: REG_IDX_W];
  assign in_rb       = in_if.in_instr[RB_LSB +: REG_IDX_W];
  assign in_br       = in_if.in_instr[BR_LSB +: BR_W];
  assign unused_rsvd = in_if.in_instr[RSV_BIT];

  // The I-stage registers double as the W stage: the instruction they hold
  // is retired at the next rising edge using the live ALU result.
  logic                 i_valid;
  logic [REG_IDX_W-1:0] i_rd;
  logic                 ready_en;

  logic                 w_writes;
  logic                 w_taken;
  logic [DATA_W-1:0]    w_data;
  logic [DATA_W-1:0]    rf_a, rf_b;
  logic [DATA_W-1:0]    fwd_a, fwd_b;
  logic                 accept;

  assign w_writes = i_valid && op_writes_reg(alu_instr);
  assign w_taken  = i_valid && (alu_instr == OP_BEQ) && eq_flag;
  assign w_data   = (alu_instr == OP_EQ) ? {{(DATA_W-1){1'b0}}, alu_out[0]} : alu_out;

  assign in_if.in_ready = ready_en && !w_taken;
  assign accept         = in_if.in_valid && in_if.in_ready;

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_idx  (in_ra),
    .rb_idx  (in_rb),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (w_writes),
    .wr_idx  (i_rd),
    .wr_data (w_data)
  );

  // The register file is written at the same edge that issues the next
  // instruction, so a matching destination must bypass the array.
  assign fwd_a = (w_writes && (i_rd == in_ra)) ? w_data : rf_a;
  assign fwd_b = (w_writes && (i_rd == in_rb)) ? w_data : rf_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en        <= 1'b0;
      i_valid         <= 1'b0;
      i_rd            <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_instr       <= OP_NOP;
      alu_branch_addr <= '0;
      wb_valid        <= 1'b0;
      wb_reg          <= '0;
      wb_data         <= '0;
      carry_flag      <= 1'b0;
      eq_flag         <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_addr   <= '0;
      retired_count   <= '0;
    end else begin
      ready_en <= 1'b1;

      if (accept) begin
        i_valid         <= 1'b1;
        i_rd            <= in_rd;
        alu_a           <= fwd_a;
        alu_b           <= fwd_b;
        alu_instr       <= in_op;
        alu_branch_addr <= in_br;
      end else begin
        i_valid   <= 1'b0;
        alu_instr <= OP_NOP;
      end

      wb_valid <= w_writes;
      if (w_writes) begin
        wb_reg  <= i_rd;
        wb_data <= w_data;
      end

      redirect_valid <= w_taken;
      if (w_taken) redirect_addr <= alu_branch_addr;

      if (i_valid) begin
        retired_count <= retired_count + CNT_W'(1);
        case (alu_instr)
          OP_ADD, OP_SUB: carry_flag <= alu_co;
          OP_EQ:          eq_flag    <= alu_out[0];
          OP_BEQ:         eq_flag    <= 1'b0;
          default:        ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, a writeback
// scoreboard and hand-computed register/flag/count expectations.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if in_if ();

  logic [7:0]       alu_a, alu_b, alu_out, wb_data;
  logic [2:0]       alu_instr;
  logic [5:0]       alu_branch_addr, redirect_addr;
  logic             alu_co, wb_valid, carry_flag, eq_flag, redirect_valid;
  logic [1:0]       wb_reg;
  logic [CNT_W-1:0] retired_count;

  alu_issue_ctrl #(.NREGS(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_if           (in_if.slave),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_instr       (alu_instr),
    .alu_branch_addr (alu_branch_addr),
    .alu_out         (alu_out),
    .alu_co          (alu_co),
    .wb_valid        (wb_valid),
    .wb_reg          (wb_reg),
    .wb_data         (wb_data),
    .carry_flag      (carry_flag),
    .eq_flag         (eq_flag),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .retired_count   (retired_count)
  );

  // Behavioural ALU; carry on SUB is the borrow (a < b).
  always_comb begin
    alu_out = 8'h00;
    alu_co  = 1'b0;
    case (alu_instr)
      OP_ADD: {alu_co, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: begin alu_out = alu_a - alu_b; alu_co = (alu_a < alu_b); end
      OP_AND: alu_out = alu_a & alu_b;
      OP_NOT: alu_out = ~alu_a;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_EQ:  alu_out = {7'b0, alu_a == alu_b};
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [9:0] exp_q[$];
  logic [5:0] exp_redir_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writeback / redirect scoreboard.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) check("wb_spurious", wb_valid, 1'b0);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("wb_reg", wb_reg, e[9:8]);
        check("wb_data", wb_data, e[7:0]);
      end
    end
    if (redirect_valid) begin
      if (exp_redir_q.size() == 0) check("redir_spurious", redirect_valid, 1'b0);
      else check("redir_addr", redirect_addr, exp_redir_q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [5:0] br,
                       input logic exp_we, input logic [7:0] exp_data);
    int waited = 0;
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = {op, rd, ra, rb, 1'(($urandom_range(0, 1))), br};
    while (!in_if.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_if.in_ready) check("issue_ready_timeout", in_if.in_ready, 1'b1);
    if (exp_we) exp_q.push_back({rd, exp_data});
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    idle(2);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_instr = '0;
    idle(2);
    // Reset values while rst is held.
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_instr", alu_instr, OP_NOP);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_redir_addr", redirect_addr, 6'h00);
    check("rst_flags", {carry_flag, eq_flag}, 2'b00);
    check("rst_count", retired_count, 16'h0000);
    rst = 1'b0;
    #1;
    check("ready_before_edge", in_if.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", in_if.in_ready, 1'b1);

    // Build R1=5, R2=3 from zeroed registers, heavily using forwarding.
    issue(OP_NOT, 2'd1, 2'd0, 2'd0, 6'h00, 1'b1, 8'hFF);
    issue(OP_SUB, 2'd2, 2'd0, 2'd1, 6'h00, 1'b1, 8'h01);
    issue(OP_ADD, 2'd3, 2'd2, 2'd2, 6'h00, 1'b1, 8'h02);
    issue(OP_ADD, 2'd1, 2'd3, 2'd3, 6'h00, 1'b1, 8'h04);
    issue(OP_ADD, 2'd1, 2'd1, 2'd2, 6'h00, 1'b1, 8'h05);
    issue(OP_ADD, 2'd2, 2'd3, 2'd2, 6'h00, 1'b1, 8'h03);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 6'h00, 1'b1, 8'h08);
    check("add_op_a", alu_a, 8'h05);
    check("add_op_b_fwd", alu_b, 8'h03);
    idle(2);
    check("add_carry0", carry_flag, 1'b0);
    check("count_7", retired_count, 16'(exp_cnt));

    // 0xFF + 0x01 then SUB consuming the forwarded zero.
    issue(OP_NOT, 2'd1, 2'd0, 2'd0, 6'h00, 1'b1, 8'hFF);
    issue(OP_SUB, 2'd2, 2'd0, 2'd1, 6'h00, 1'b1, 8'h01);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 6'h00, 1'b1, 8'h00);
    issue(OP_SUB, 2'd0, 2'd3, 2'd2, 6'h00, 1'b1, 8'hFF);
    check("add_wrap_carry1", carry_flag, 1'b1);
    check("sub_fwd_a", alu_a, 8'h00);
    idle(2);
    check("sub_borrow", carry_flag, 1'b1);

    // Taken branch with a younger word offered during its W cycle.
    issue(OP_EQ, 2'd0, 2'd1, 2'd1, 6'h00, 1'b1, 8'h01);
    exp_redir_q.push_back(6'h2A);
    issue(OP_BEQ, 2'd0, 2'd0, 2'd0, 6'h2A, 1'b0, 8'h00);
    @(negedge clk);
    check("beq_eq_seen", eq_flag, 1'b1);
    check("flush_ready", in_if.in_ready, 1'b0);
    in_if.in_valid = 1'b1;
    in_if.in_instr = {OP_ADD, 2'd3, 2'd1, 2'd1, 1'b0, 6'h00};
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    check("redirect_pulse", redirect_valid, 1'b1);
    check("beq_eq_cleared", eq_flag, 1'b0);
    check("beq_carry_hold", carry_flag, 1'b1);
    idle(2);
    check("count_taken", retired_count, 16'(exp_cnt));

    // Unequal compare, not-taken branch.
    issue(OP_EQ, 2'd3, 2'd1, 2'd2, 6'h00, 1'b1, 8'h00);
    issue(OP_BEQ, 2'd0, 2'd0, 2'd0, 6'h15, 1'b0, 8'h00);
    idle(2);
    check("nt_eq_flag", eq_flag, 1'b0);
    check("nt_count", retired_count, 16'(exp_cnt));
    check("nt_count_abs", retired_count, 16'd15);

    // Asynchronous reset while an ADD sits in W.
    issue(OP_ADD, 2'd0, 2'd1, 2'd1, 6'h00, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    check("arst_alu_instr", alu_instr, OP_NOP);
    check("arst_count", retired_count, 16'h0000);
    check("arst_flags", {carry_flag, eq_flag}, 2'b00);
    @(negedge clk);
    check("arst_wb_valid", wb_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(OP_OR, 2'd0, 2'd1, 2'd2, 6'h00, 1'b1, 8'h00);
    check("arst_r1_r2", {alu_a, alu_b}, 16'h0000);
    check("arst_or_op", alu_instr, OP_OR);
    issue(OP_OR, 2'd1, 2'd3, 2'd0, 6'h00, 1'b1, 8'h00);
    check("arst_r3", alu_a, 8'h00);
    idle(2);
    check("arst_count2", retired_count, 16'd2);

    // Continuous NOP stream wrapping the retired counter.
    do_reset();
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = {OP_NOP, 13'h0};
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    idle(2);
    check("nop_wrap_count", retired_count, 16'd3);
    check("nop_flags", {carry_flag, eq_flag}, 2'b00);

    check("wb_q_drained", exp_q.size(), 0);
    check("redir_q_drained", exp_redir_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that drives the 8-bit ALU's operand, opcode and branch-address inputs, and consumes its result and carry.
- Accepts 16-bit instruction words on a valid/ready stream and reads operands from an internal 4x8 register file.
- Registers operands toward the ALU, writes results back one cycle later, owns the carry and equal flags, and issues branch redirects to fetch.
- Sits between the fetch/instruction buffer and the ALU datapath.

Parameters:
- NREGS, 4, register-file depth (register index width = 2; fixed for this revision).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_instr  in  16  [15:13] op, [12:11] rd, [10:9] ra, [8:7] rb, [6] reserved, [5:0] branch target.
- alu_a  out  8  ALU operand A (registered).
- alu_b  out  8  ALU operand B (registered).
- alu_instr  out  3  ALU opcode (registered).
- alu_branch_addr  out  6  branch target to the ALU (registered).
- alu_out  in  8  ALU result; combinational from alu_a/alu_b/alu_instr.
- alu_co  in  1  ALU carry/borrow.
- wb_valid  out  1  one-cycle pulse per register write.
- wb_reg  out  2  destination register of the write.
- wb_data  out  8  written value.
- carry_flag  out  1  architectural carry.
- eq_flag  out  1  architectural equal flag.
- redirect_valid  out  1  one-cycle pulse on a taken branch.
- redirect_addr  out  6  branch target.
- retired_count  out  CNT_W  instructions retired (wraps).

Behaviour:
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 NOT (A only), 101 OR, 110 EQ, 111 BEQ.
- Two stages:
  - I: on an accepted instruction, register alu_a = R[ra], alu_b = R[rb], alu_instr, alu_branch_addr, rd and a valid bit.
  - W: in the following cycle, sample alu_out and alu_co and retire at that cycle's closing edge.
- Latency: instruction accepted at edge N; wb_valid, wb_data, flags and redirect are visible after edge N+1. Throughput is one instruction per cycle.
- Writeback, performed at the W edge:
  - ADD/SUB/AND/NOT/OR: R[rd] = alu_out.
  - ADD/SUB also set carry_flag = alu_co.
  - EQ: R[rd] = {7'b0, alu_out[0]} and eq_flag = alu_out[0].
  - NOP and BEQ do not write a register.
  - carry_flag holds on every op except ADD/SUB.
- BEQ:
  - If eq_flag is 1 at W, pulse redirect_valid with redirect_addr = target.
  - Whether taken or not, eq_flag is cleared and carry_flag holds.
- Flush on a taken branch: the instruction in I that cycle (younger) is invalidated, so it does not write and is not counted. in_ready = 0 during the W cycle of a taken BEQ.
- in_ready is 1 at all other times; there is no other stall source.
- Forwarding:
  - At I, if W is valid, writes a register, and rd == ra (or rb), the forwarded operand is the W writeback value (alu_out, or {7'b0, alu_out[0]} for EQ).
  - A BEQ in I after an EQ in W is not affected, because W updates eq_flag before BEQ reaches W.
- A bubble (no accept) loads I with valid = 0 and alu_instr = 000; operands hold.
- retired_count increments once per W instruction, including NOP and not-taken BEQ; taken BEQ also counts. It wraps at 2^CNT_W.
- Arithmetic is 8-bit modulo; ALU width rules apply unchanged.
- Reset (any time, including mid-instruction), all asynchronously:
  - Register file, flags and retired_count go to 0.
  - Both stage valid bits go to 0.
  - alu_a, alu_b, alu_instr and alu_branch_addr go to 0.
  - wb_valid, redirect_valid and redirect_addr go to 0.
  - In-flight instructions are discarded.
- in_ready is 1 from the first edge after rst deasserts.
- The reserved bit [6] is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NOP..OP_BEQ (3'b000..3'b111);
  - instruction field positions and widths;
  - the register-index width.
- One natural sub-module, alu_regfile: 4x8, two combinational read ports, one write port, asynchronous reset to 0.
- Decode, forwarding, flags and flush stay in the top module.

Test Plan:
- Reset, then R1=0x05 and R2=0x03 via ADD from seeded values, then ADD rd=3 ra=1 rb=2 -> wb_valid at N+1 with wb_reg=3, wb_data=0x08, carry_flag=0.
- ADD on 0xFF+0x01 then back-to-back SUB using rd as ra -> first wb_data=0x00 with carry_flag=1; SUB uses the forwarded 0x00, not the stale register value.
- EQ R1,R1 rd=0 then BEQ target=0x2A, then an ADD in the next cycle -> redirect_valid pulse with addr 0x2A and eq_flag cleared; the ADD is flushed (no wb_valid); in_ready=0 that cycle.
- EQ on unequal values then BEQ -> R[rd]=0x00, no redirect, eq_flag=0, retired_count advances by 2.
- Assert rst in the cycle an ADD sits in W -> no wb_valid; all registers, flags and count are 0; alu_instr=000.
- Continuous NOP stream of 2^CNT_W+3 words -> retired_count wraps to 3 and no wb_valid ever asserts.
